// File: rtl/fetch_unit.sv
// fetch_unit: PC generation and fetch control ahead of a synchronous instruction memory.
// Issues one read per cycle, buffers returned words in a 2-entry FIFO (with a
// bypass path when empty), and hands {pc, instr} to decode over valid/ready.
// Execute redirects flush all buffered and in-flight words and restart at the target.
//
// Ports:
//   clk             clock, all state updates on rising edge
//   rst             synchronous active-low reset
//   redirect_valid  execute requests a redirect this cycle
//   redirect_pc     redirect target byte address (low two bits dropped)
//   imem_pc         read address to instruction memory (combinational)
//   imem_data       memory read data for the address sampled at the previous edge
//   if_valid        {if_pc, if_instr} valid to decode
//   if_ready        decode accepts
//   if_pc           PC of presented instruction
//   if_instr        presented instruction word
//   fetch_misalign  one-cycle pulse after a redirect whose target was unaligned
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        fetch_misalign
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNT_W = 2;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Architectural state
   logic [XLEN-1:0]  pc_q;
   logic             req_valid_q;
   logic [XLEN-1:0]  req_pc_q;
   fetch_entry_t     fifo_q [DEPTH];
   logic             head_q;
   logic             tail_q;
   logic [CNT_W-1:0] count_q;
   logic             misalign_q;

   // Combinational helpers
   logic [XLEN-1:0]  tgt;
   logic             fifo_empty;
   logic             pop;
   logic             push;
   logic             head_adv;
   logic [CNT_W-1:0] occ_after;
   logic             issue;

   // Redirect target with the byte offset dropped
   assign tgt = {redirect_pc[XLEN-1:2], 2'b00};

   // Memory address: reset PC while in reset, redirect target takes priority otherwise
   always_comb begin
      imem_pc = pc_q;
      if (!rst) begin
         imem_pc = RESET_PC;
      end else if (redirect_valid) begin
         imem_pc = tgt;
      end
   end

   // Output select: FIFO head when buffered, otherwise bypass the returning read
   always_comb begin
      fifo_empty = (count_q == CNT_W'(0));
      if_valid   = !fifo_empty || req_valid_q;
      if_pc      = req_pc_q;
      if_instr   = imem_data;
      if (!fifo_empty) begin
         if_pc    = fifo_q[head_q].pc;
         if_instr = fifo_q[head_q].instr;
      end
   end

   // Handshake and flow control; a handshake coinciding with a redirect is void
   always_comb begin
      pop       = if_valid && if_ready && !redirect_valid;
      // Returning word is consumed directly only when it was the one presented
      push      = req_valid_q && !(fifo_empty && pop);
      head_adv  = pop && !fifo_empty;
      // Occupancy (buffered + in flight) after this cycle's pop; never below zero
      // because pop implies at least one word is present
      occ_after = count_q + CNT_W'(req_valid_q) - CNT_W'(pop);
      issue     = (occ_after < CNT_W'(DEPTH));
   end

   // Control state: PC, in-flight read tag, FIFO pointers and count
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q        <= RESET_PC;
         req_valid_q <= 1'b0;
         req_pc_q    <= RESET_PC;
         head_q      <= 1'b0;
         tail_q      <= 1'b0;
         count_q     <= '0;
         misalign_q  <= 1'b0;
      end else begin
         misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
         if (redirect_valid) begin
            // Flush buffered and in-flight words; target read issues unconditionally
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            count_q     <= '0;
            req_valid_q <= 1'b1;
            req_pc_q    <= tgt;
            pc_q        <= tgt + XLEN'(4);
         end else begin
            if (push) begin
               tail_q <= ~tail_q;
            end
            if (head_adv) begin
               head_q <= ~head_q;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(head_adv);
            if (issue) begin
               req_valid_q <= 1'b1;
               req_pc_q    <= pc_q;
               pc_q        <= pc_q + XLEN'(4);
            end else begin
               // Memory still reads pc_q this cycle; the result is dropped
               req_valid_q <= 1'b0;
            end
         end
      end
   end

   // FIFO storage; contents are meaningful only below count_q, so no reset needed
   always_ff @(posedge clk) begin
      if (rst && !redirect_valid && push) begin
         fifo_q[tail_q] <= '{pc: req_pc_q, instr: imem_data};
      end
   end

   assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit.
// The reference keeps the ordered list of fetched-but-unconsumed PCs as a queue
// plus the next PC to fetch, and checks every cycle's outputs against it.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_pc;
   logic [31:0] imem_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        fetch_misalign;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state
   logic [31:0] mq[$];
   logic [31:0] mnext;
   logic        mmis;
   bit          minit = 0;

   fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_pc        (imem_pc),
      .imem_data      (imem_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .fetch_misalign (fetch_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h100 + (a >> 2);
   endfunction

   // Synchronous instruction memory: word for the address sampled at the edge
   always @(posedge clk) imem_data <= mem_word(imem_pc);

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endfunction

   // Outputs that must be visible given the reference state and current inputs
   function automatic void compare();
      logic [31:0] exp_imem;
      if (!minit) return;
      if (!rst) exp_imem = RESET_PC;
      else if (redirect_valid) exp_imem = {redirect_pc[31:2], 2'b00};
      else exp_imem = mnext;
      chk("imem_pc", imem_pc, exp_imem);
      chk("if_valid", 32'(if_valid), 32'(mq.size() != 0));
      chk("fetch_misalign", 32'(fetch_misalign), 32'(mmis));
      if (mq.size() != 0) begin
         chk("if_pc", if_pc, mq[0]);
         chk("if_instr", if_instr, mem_word(mq[0]));
      end
   endfunction

   // Reference update at a rising edge using the inputs held during the cycle
   function automatic void model_step();
      logic [31:0] t;
      if (!rst) begin
         mq.delete();
         mnext = RESET_PC;
         mmis  = 1'b0;
         minit = 1;
      end else if (minit) begin
         mmis = redirect_valid && (redirect_pc[1:0] != 2'b00);
         if (redirect_valid) begin
            t = {redirect_pc[31:2], 2'b00};
            mq.delete();
            mq.push_back(t);
            mnext = t + 32'd4;
         end else begin
            if (mq.size() != 0 && if_ready) void'(mq.pop_front());
            if (mq.size() < 2) begin
               mq.push_back(mnext);
               mnext = mnext + 32'd4;
            end
         end
      end
   endfunction

   task automatic tick();
      @(negedge clk);
      compare();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_in(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
      rst            = r;
      redirect_valid = rv;
      redirect_pc    = rp;
      if_ready       = rdy;
   endtask

   initial begin
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      repeat (3) tick();

      // Reset release and full-rate streaming
      chk("lit_reset_valid", 32'(if_valid), 32'd0);
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      chk("lit_first_valid", 32'(if_valid), 32'd1);
      chk("lit_first_pc", if_pc, 32'h0);
      chk("lit_first_instr", if_instr, 32'h100);
      tick();
      chk("lit_second_pc", if_pc, 32'h4);
      chk("lit_second_instr", if_instr, 32'h101);
      repeat (6) tick();

      // Back-pressure for 5 cycles, then release
      set_in(1'b1, 1'b0, 32'h0, 1'b0);
      repeat (5) tick();
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      repeat (6) tick();

      // Aligned redirect while streaming
      set_in(1'b1, 1'b1, 32'h40, 1'b1);
      tick();
      chk("lit_redirect_pc", if_pc, 32'h40);
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      chk("lit_redirect_next", if_pc, 32'h44);
      repeat (3) tick();

      // Redirect with FIFO full and a read in flight
      set_in(1'b1, 1'b0, 32'h0, 1'b0);
      repeat (4) tick();
      set_in(1'b1, 1'b1, 32'h80, 1'b0);
      tick();
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      chk("lit_flush_pc", if_pc, 32'h80);
      repeat (3) tick();

      // Unaligned redirect
      set_in(1'b1, 1'b1, 32'h42, 1'b1);
      tick();
      chk("lit_misalign_set", 32'(fetch_misalign), 32'd1);
      chk("lit_misalign_pc", if_pc, 32'h40);
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      chk("lit_misalign_clr", 32'(fetch_misalign), 32'd0);

      // Address wrap
      set_in(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
      tick();
      chk("lit_wrap_top", if_pc, 32'hFFFF_FFFC);
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      chk("lit_wrap_zero", if_pc, 32'h0);
      repeat (2) tick();

      // Reset coinciding with a redirect while FIFO holds two entries
      set_in(1'b1, 1'b0, 32'h0, 1'b0);
      repeat (4) tick();
      set_in(1'b0, 1'b1, 32'h200, 1'b0);
      tick();
      chk("lit_rst_valid", 32'(if_valid), 32'd0);
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      chk("lit_rst_pc", if_pc, RESET_PC);
      repeat (3) tick();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic        r;
         logic        rv;
         logic [31:0] rp;
         r  = ($urandom_range(0, 99) >= 2);
         rv = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         else rp = $urandom;
         set_in(r, rv, rp, ($urandom_range(0, 9) < 7));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- PC generation and fetch-control stage directly upstream of the instruction memory.
- Drives the memory read address and tags each synchronous read, which returns one cycle later.
- Buffers the returned instruction words and presents {pc, instr} to decode over a valid/ready handshake.
- Handles decode back-pressure and branch/jump redirects from execute without losing, duplicating or leaking wrong-path instructions.

Parameters:
- RESET_PC, 32'h0000_0000: PC fetched first after reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- redirect_valid  in  1  execute requests a fetch redirect this cycle.
- redirect_pc  in  32  redirect target byte address.
- imem_pc  out  32  byte address to the instruction memory pc_in; sampled by memory at the rising edge.
- imem_data  in  32  instruction memory data_out; holds word for the address sampled at the previous edge.
- if_valid  out  1  {if_pc, if_instr} valid to decode.
- if_ready  in  1  decode accepts; transfer occurs at an edge where if_valid and if_ready are both 1.
- if_pc  out  32  PC of presented instruction.
- if_instr  out  32  presented instruction word.
- fetch_misalign  out  1  one-cycle pulse: last redirect target had bits [1:0] != 0.

Behaviour:
- State:
  - pc_q: next PC to fetch.
  - req_valid_q / req_pc_q: a read issued at the previous edge and not killed.
  - 2-entry FIFO of {pc, instr}, with count (0..2), head and tail pointers.
- Aligned target: tgt = {redirect_pc[31:2], 2'b00}.
- imem_pc (combinational): redirect_valid ? tgt : pc_q.
- pop = if_valid & if_ready & ~redirect_valid. A handshake in a redirect cycle is void.
- Output select:
  - if_valid = (count != 0) | req_valid_q.
  - count != 0: if_pc/if_instr = FIFO head.
  - Otherwise (bypass): if_pc = req_pc_q, if_instr = imem_data.
  - if_pc/if_instr are don't-care when if_valid = 0.
- Issue condition: issue = (count + req_valid_q - pop) < 2. This guarantees count + req_valid_q <= 2 at all times, so no FIFO overflow.
- Normal edge (rst = 1, redirect_valid = 0):
  - If req_valid_q and not (count == 0 and pop): push {req_pc_q, imem_data} into FIFO.
  - If pop and count != 0: advance head.
  - count updates accordingly.
  - If issue: req_valid_q <= 1, req_pc_q <= pc_q, pc_q <= pc_q + 4.
  - If not issue: req_valid_q <= 0, pc_q holds. The memory still reads pc_q; the result is ignored.
- Redirect edge (rst = 1, redirect_valid = 1):
  - FIFO flushed: count <= 0, pointers reset.
  - In-flight read killed.
  - Target read issues unconditionally: req_valid_q <= 1, req_pc_q <= tgt, pc_q <= tgt + 4.
  - Target instruction is valid in the cycle after the redirect edge, giving a 1-cycle bubble.
- fetch_misalign <= redirect_valid & (redirect_pc[1:0] != 0). Cleared the following cycle unless re-asserted.
- Reset (rst = 0 at an edge) has priority over everything:
  - pc_q <= RESET_PC; req_valid_q, count, pointers, fetch_misalign <= 0.
  - if_valid is 0 from the first reset edge.
  - imem_pc = RESET_PC while in reset (redirect_valid is ignored during reset).
  - The first edge with rst = 1 issues RESET_PC; if_valid rises the cycle after.
- Reset mid-operation: all buffered and in-flight words are discarded with no residual output.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Throughput: with if_ready held at 1, one instruction per cycle, and count stays 0 via bypass.
- Back-pressure:
  - When if_ready drops, up to 2 words are captured.
  - PC stalls once count + req_valid_q reaches 2.
  - Order is strictly preserved.

Test Plan:
1. Reset, RESET_PC = 0, mem[i] = 32'h100 + i, if_ready = 1 → imem_pc goes 0, 4, 8, …; if_valid high from the 2nd post-reset cycle; if_pc/if_instr = (0, 0x100), (4, 0x101), … one per cycle with no gaps.
2. Mid-stream if_ready = 0 for 5 cycles, then 1 → FIFO fills to count 2 and imem_pc freezes. After release, if_pc continues consecutively with no drop or duplicate; full rate resumes.
3. Streaming, redirect_valid pulse with redirect_pc = 0x40 → one bubble cycle, then if_pc = 0x40, 0x44, …; no old-path PC appears after the redirect edge.
4. if_ready = 0 with FIFO full and a read in flight, redirect to 0x80 → FIFO flushed; next accepted if_pc = 0x80.
5. Redirect to 0x42 → fetch resumes at 0x40 and fetch_misalign pulses exactly one cycle. Separately, redirect to 0xFFFF_FFFC → if_pc = 0xFFFF_FFFC then 0x0000_0000.
6. rst = 0 asserted simultaneously with redirect_valid while FIFO holds 2 entries → if_valid = 0 next cycle. After release, the first if_pc = RESET_PC, not the redirect target.
